jelly3_stream_unpacker: RTL and testbench

- Width down-converter for ready/valid streams. Accepts one wide word of NUM units on the slave port and emits its units one per beat, LSB unit first, on the master port.
- Typical placement: directly upstream of jelly3_skid_buffer, which absorbs its ready timing. It can also sit downstream of the skid buffer when a registered wide source needs serialising.
- Zero-bubble: back-to-back words stream at one unit per cycle when m_ready stays high.

---
 rtl/jelly3_stream_unpacker.sv | 119 +++++++++++
 tb/tb_jelly3_stream_unpacker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly3_stream_unpacker.sv
// jelly3_stream_unpacker
//   Width down-converter for ready/valid streams. One wide word of NUM units
//   is accepted on the slave port and its units are emitted one per beat,
//   LSB unit first, on the master port. Back-to-back words stream without a
//   bubble while m_ready stays high.
//
// Ports
//   reset    in   synchronous active-high reset (wins over cke)
//   clk      in   clock, all state on rising edge
//   cke      in   clock enable; when low all state holds, no handshake completes
//   s_len    in   [IDX_BITS]    index of the last unit to emit (LEN_EN build only)
//   s_data   in   [S_DATA_BITS] wide word, unit k at [k*UNIT_BITS +: UNIT_BITS]
//   s_valid  in   input word valid
//   s_ready  out  input word accepted when s_valid && s_ready && cke
//   m_data   out  [UNIT_BITS]   current output unit
//   m_last   out  final unit of the current word
//   m_valid  out  output unit valid
//   m_ready  in   downstream ready
//   busy     out  a word is held (equals m_valid)
//
// Configuration macro
//   JELLY3_STREAM_UNPACKER_LEN_EN : adds s_len so each word may emit fewer
//   than NUM units. Undefined: every word emits all NUM units.

module jelly3_stream_unpacker #(
  parameter int NUM         = 4,
  parameter int UNIT_BITS   = 8,
  parameter int S_DATA_BITS = NUM * UNIT_BITS,
  parameter int IDX_BITS    = (NUM > 1 ? $clog2(NUM) : 1),
  parameter     DEVICE      = "RTL",
  parameter     SIMULATION  = "false",
  parameter     DEBUG       = "false"
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   cke,
`ifdef JELLY3_STREAM_UNPACKER_LEN_EN
  input  logic [IDX_BITS-1:0]    s_len,
`endif
  input  logic [S_DATA_BITS-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [UNIT_BITS-1:0]   m_data,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM - 1);

  logic                   reg_valid;
  logic [S_DATA_BITS-1:0] reg_data;
  logic [IDX_BITS-1:0]    reg_idx;
  logic [IDX_BITS-1:0]    reg_last_idx;
  logic [IDX_BITS-1:0]    next_last_idx;
  logic                   s_fire;
  logic                   m_fire;

`ifdef JELLY3_STREAM_UNPACKER_LEN_EN
  assign next_last_idx = s_len;
`else
  assign next_last_idx = LAST_IDX;
`endif

  assign m_valid = reg_valid;
  assign busy    = reg_valid;
  assign m_last  = reg_valid && (reg_idx == reg_last_idx);

  // Combinational from m_ready so the next word is taken on the same cycle
  // the last unit of the current word leaves: this is what removes the bubble.
  assign s_ready = !reset && (!reg_valid || (m_ready && m_last));

  assign s_fire = cke && s_valid && s_ready;
  assign m_fire = cke && m_valid && m_ready;

  // Unit select as a mux over constant slices; reg_idx never exceeds
  // reg_last_idx, so an out-of-range index cannot occur.
  always_comb begin
    // NOTE: default first so every path assigns m_data and no latch is inferred.
    m_data = '0;
    for (int k = 0; k < NUM; k++) begin
      if (reg_idx == IDX_BITS'(k)) begin
        m_data = reg_data[k*UNIT_BITS +: UNIT_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      reg_valid    <= 1'b0;
      reg_idx      <= '0;
      reg_last_idx <= LAST_IDX;
    end else if (cke) begin
      if (s_fire) begin
        reg_valid    <= 1'b1;
        reg_idx      <= '0;
        reg_last_idx <= next_last_idx;
      end else if (m_fire && m_last) begin
        reg_valid <= 1'b0;
        reg_idx   <= '0;
      end else if (m_fire) begin
        reg_idx <= reg_idx + 1'b1;
      end
    end
  end

  // NOTE: the data register is deliberately not reset; it is only observed
  // while reg_valid is high, and leaving it out of reset keeps it a plain
  // enable flop.
  always_ff @(posedge clk) begin
    if (cke && s_fire) begin
      reg_data <= s_data;
    end
  end

endmodule

// File: tb/tb_jelly3_stream_unpacker.sv
// Self-checking bench for jelly3_stream_unpacker (NUM=4, UNIT_BITS=8).
// Directed cycle table for the corner cases, then randomized traffic checked
// against a queue-based model of the word-to-unit serialisation.

module tb_jelly3_stream_unpacker;

  localparam int NUM       = 4;
  localparam int UNIT_BITS = 8;
  localparam int IDX_BITS  = 2;

  logic        reset;
  logic        clk;
  logic        cke;
  logic [IDX_BITS-1:0] s_len;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  jelly3_stream_unpacker #(
    .NUM       (NUM),
    .UNIT_BITS (UNIT_BITS)
  ) dut (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
`ifdef JELLY3_STREAM_UNPACKER_LEN_EN
    .s_len   (s_len),
`endif
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One table row = inputs for one cycle and the outputs expected before
  // the rising edge that samples them.
  typedef struct {
    logic                rst;
    logic                ce;
    logic                sv;
    logic [31:0]         sd;
    logic [IDX_BITS-1:0] len;
    logic                mr;
    logic                e_mv;
    logic [7:0]          e_md;
    logic                e_ml;
    logic                e_sr;
  } vec_t;

  vec_t vecs[$];
  logic [IDX_BITS-1:0] cur_len = 2'd3;

  task automatic v(input logic rst, input logic ce, input logic sv, input logic [31:0] sd,
                   input logic mr, input logic e_mv, input logic [7:0] e_md,
                   input logic e_ml, input logic e_sr);
    vec_t r;
    r.rst = rst; r.ce = ce; r.sv = sv; r.sd = sd; r.len = cur_len; r.mr = mr;
    r.e_mv = e_mv; r.e_md = e_md; r.e_ml = e_ml; r.e_sr = e_sr;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic rst, input logic ce, input logic sv, input logic [31:0] sd,
                       input logic [IDX_BITS-1:0] len, input logic mr);
    reset = rst; cke = ce; s_valid = sv; s_data = sd; s_len = len; m_ready = mr;
  endtask

  // Reference model: the held word is a queue of {last, unit} beats.
  logic [8:0] beats[$];

  task automatic model_load(input logic [31:0] sd, input int last_idx);
    logic [31:0] w;
    beats.delete();
    w = sd;
    for (int k = 0; k <= last_idx; k++) begin
      beats.push_back({(k == last_idx), w[7:0]});
      w = w >> 8;
    end
  endtask

  localparam logic [31:0] W0 = 32'h44332211;
  localparam logic [31:0] W1 = 32'h88776655;
  localparam logic [31:0] WL = 32'hDDCCBBAA;

  initial begin
    drive(1'b1, 1'b1, 1'b0, '0, 2'd3, 1'b1);

    // reset state
    v(1,1,0,0 ,1, 0,8'h00,0,0);
    // single word
    v(0,1,1,W0,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'h11,0,0);
    v(0,1,0,0 ,1, 1,8'h22,0,0);
    v(0,1,0,0 ,1, 1,8'h33,0,0);
    v(0,1,0,0 ,1, 1,8'h44,1,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    // back-to-back words, no bubble
    v(0,1,1,W0,1, 0,8'h00,0,1);
    v(0,1,1,W1,1, 1,8'h11,0,0);
    v(0,1,1,W1,1, 1,8'h22,0,0);
    v(0,1,1,W1,1, 1,8'h33,0,0);
    v(0,1,1,W1,1, 1,8'h44,1,1);
    v(0,1,0,0 ,1, 1,8'h55,0,0);
    v(0,1,0,0 ,1, 1,8'h66,0,0);
    v(0,1,0,0 ,1, 1,8'h77,0,0);
    v(0,1,0,0 ,1, 1,8'h88,1,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    // backpressure on unit 22
    v(0,1,1,W0,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'h11,0,0);
    v(0,1,0,0 ,0, 1,8'h22,0,0);
    v(0,1,0,0 ,0, 1,8'h22,0,0);
    v(0,1,0,0 ,0, 1,8'h22,0,0);
    v(0,1,0,0 ,1, 1,8'h22,0,0);
    v(0,1,0,0 ,1, 1,8'h33,0,0);
    v(0,1,0,0 ,1, 1,8'h44,1,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    // cke gating mid-word, and cke=0 with an offered word at idle
    v(0,1,1,W0,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'h11,0,0);
    v(0,0,0,0 ,1, 1,8'h22,0,0);
    v(0,0,0,0 ,1, 1,8'h22,0,0);
    v(0,1,0,0 ,1, 1,8'h22,0,0);
    v(0,1,0,0 ,1, 1,8'h33,0,0);
    v(0,1,0,0 ,1, 1,8'h44,1,1);
    v(0,0,1,W0,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    // reset mid-word, then a fresh word starts at unit 0
    v(0,1,1,W1,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'h55,0,0);
    v(0,1,0,0 ,1, 1,8'h66,0,0);
    v(1,1,0,0 ,1, 1,8'h77,0,0);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    v(0,1,1,W0,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'h11,0,0);
    v(0,1,0,0 ,1, 1,8'h22,0,0);
    v(0,1,0,0 ,1, 1,8'h33,0,0);
    v(0,1,0,0 ,1, 1,8'h44,1,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
`ifdef JELLY3_STREAM_UNPACKER_LEN_EN
    // shortened words
    cur_len = 2'd1;
    v(0,1,1,WL,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'hAA,0,0);
    v(0,1,0,0 ,1, 1,8'hBB,1,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    cur_len = 2'd3;
    v(0,1,1,WL,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'hAA,0,0);
    v(0,1,0,0 ,1, 1,8'hBB,0,0);
    v(0,1,0,0 ,1, 1,8'hCC,0,0);
    v(0,1,0,0 ,1, 1,8'hDD,1,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    cur_len = 2'd0;
    v(0,1,1,WL,1, 0,8'h00,0,1);
    v(0,1,0,0 ,1, 1,8'hAA,1,1);
    v(0,1,0,0 ,1, 0,8'h00,0,1);
    cur_len = 2'd3;
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ce, vecs[i].sv, vecs[i].sd, vecs[i].len, vecs[i].mr);
      @(negedge clk);
      check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      check($sformatf("vec%0d busy", i),    32'(busy),    32'(vecs[i].e_mv));
      check($sformatf("vec%0d m_last", i),  32'(m_last),  32'(vecs[i].e_ml));
      check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
      if (vecs[i].e_mv) check($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].e_md));
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the queue model.
    beats.delete();
    for (int c = 0; c < 3000; c++) begin
      logic rst, ce, sv, mr, e_sr, sfire;
      logic [31:0] sd;
      logic [IDX_BITS-1:0] len;
      int last_idx;
      rst = (c == 0) || ($urandom_range(0, 59) == 0);
      ce  = ($urandom_range(0, 7) != 0);
      sv  = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 3) != 0);
      sd  = $urandom;
`ifdef JELLY3_STREAM_UNPACKER_LEN_EN
      len = IDX_BITS'($urandom_range(0, NUM - 1));
      last_idx = int'(len);
`else
      len = 2'd3;
      last_idx = NUM - 1;
`endif
      drive(rst, ce, sv, sd, len, mr);
      @(negedge clk);
      e_sr = !rst && (beats.size() == 0 || (mr && beats.size() == 1));
      if (c > 0) begin
        check("rnd m_valid", 32'(m_valid), 32'(beats.size() != 0));
        check("rnd busy",    32'(busy),    32'(beats.size() != 0));
        check("rnd s_ready", 32'(s_ready), 32'(e_sr));
        if (beats.size() != 0) begin
          check("rnd m_data", 32'(m_data), 32'(beats[0][7:0]));
          check("rnd m_last", 32'(m_last), 32'(beats[0][8]));
        end else begin
          check("rnd m_last", 32'(m_last), 32'd0);
        end
      end
      sfire = ce && sv && e_sr;
      if (rst) beats.delete();
      else if (sfire) model_load(sd, last_idx);
      else if (ce && mr && beats.size() != 0) void'(beats.pop_front());
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
